// File: rtl/mux_scan_seq_if.sv
// Channel bus for mux_scan_seq: packed channel inputs, mode/select/scan controls,
// and the registered channel output with its index and status flags.
interface mux_scan_seq_if #(
  parameter int unsigned N_CH = 16,
  parameter int unsigned W    = 1
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic [N_CH*W-1:0] din;
  logic              mode;
  logic [SEL_W-1:0]  sel_in;
  logic              start;
  logic              stop;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  sel_out;
  logic              valid;
  logic              wrap;

  modport master (
    output din, mode, sel_in, start, stop,
    input  dout, sel_out, valid, wrap
  );

  modport slave (
    input  din, mode, sel_in, start, stop,
    output dout, sel_out, valid, wrap
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Registered N-channel mux with manual select and a dwell-timed automatic scan.
// All outputs come straight from flops; wrap pulses on each N_CH-1 -> 0 step.
module mux_scan_seq #(
  parameter int unsigned N_CH  = 16,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 4
) (
  input logic          clk,
  input logic          rst_n,
  mux_scan_seq_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0] NChExt = N_CH[SEL_W:0];

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_dwell;
  logic [W-1:0]     r_dout;
  logic [SEL_W-1:0] r_sel;
  logic             r_valid;
  logic             r_wrap;

  logic             w_last_dwell;
  logic             w_last_ch;
  logic             w_sel_in_ok;
  logic [SEL_W-1:0] w_scan_sel;
  logic [W-1:0]     w_idle_data;
  logic [W-1:0]     w_scan_data;

  always_comb begin
    w_last_dwell = (r_dwell == CNT_W'(DWELL - 1));
    w_last_ch    = (r_sel == SEL_W'(N_CH - 1));
    w_sel_in_ok  = ({1'b0, bus.sel_in} < NChExt);
    if (!w_last_dwell) begin
      w_scan_sel = r_sel;
    end else if (w_last_ch) begin
      w_scan_sel = '0;
    end else begin
      w_scan_sel = r_sel + SEL_W'(1);
    end
    // Loop mux keeps out-of-range selects at zero instead of indexing past din.
    w_idle_data = '0;
    w_scan_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (bus.sel_in == SEL_W'(k)) w_idle_data = bus.din[k*W +: W];
      if (w_scan_sel == SEL_W'(k)) w_scan_data = bus.din[k*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_dwell <= '0;
      r_dout  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.mode && bus.start && !bus.stop) begin
            r_state <= StScan;
            r_dwell <= '0;
            r_sel   <= '0;
            r_dout  <= bus.din[W-1:0];
            r_valid <= 1'b1;
          end else begin
            r_sel   <= bus.sel_in;
            r_dout  <= w_idle_data;
            r_valid <= w_sel_in_ok;
          end
        end
        StScan: begin
          if (bus.stop || !bus.mode) begin
            r_state <= StIdle;
            r_dwell <= '0;
            r_sel   <= bus.sel_in;
            r_dout  <= w_idle_data;
            r_valid <= w_sel_in_ok;
          end else begin
            r_dwell <= w_last_dwell ? '0 : r_dwell + CNT_W'(1);
            r_sel   <= w_scan_sel;
            r_dout  <= w_scan_data;
            r_valid <= 1'b1;
            r_wrap  <= w_last_dwell && w_last_ch;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.dout    = r_dout;
  assign bus.sel_out = r_sel;
  assign bus.valid   = r_valid;
  assign bus.wrap    = r_wrap;
endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: a 16-channel/DWELL=4 instance and a 5-channel/W=4/DWELL=1
// instance, both checked against a cycle-count based model of the scan schedule.
module tb_mux_scan_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_scan_seq_if #(.N_CH(16), .W(1)) bus16 ();
  mux_scan_seq_if #(.N_CH(5), .W(4))  bus5 ();

  mux_scan_seq #(.N_CH(16), .W(1), .DWELL(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mux_scan_seq #(.N_CH(5), .W(4), .DWELL(1))  dut5  (.clk(clk), .rst_n(rst_n), .bus(bus5));

  // Model state: index 0 = 16-channel instance, 1 = 5-channel instance.
  int          m_scan [2];
  int          m_t    [2];
  int          e_sel  [2];
  logic [63:0] e_dout [2];
  logic        e_valid[2];
  logic        e_wrap [2];

  function automatic logic [63:0] chan(input logic [63:0] din, input int k, input int w);
    return (din >> (k * w)) & ((64'd1 << w) - 64'd1);
  endfunction

  // Scan position is derived from cycles elapsed since scan entry.
  task automatic step_model(input int id, input int n, input int dw, input int w,
                            input logic [63:0] din, input logic mode, input logic start,
                            input logic stop, input int sel);
    if (!rst_n) begin
      m_scan[id] = 0; m_t[id] = 0; e_sel[id] = 0;
      e_dout[id] = '0; e_valid[id] = 1'b0; e_wrap[id] = 1'b0;
    end else if (m_scan[id] == 1 && mode && !stop) begin
      m_t[id]++;
      e_sel[id]   = (m_t[id] / dw) % n;
      e_wrap[id]  = (m_t[id] % (n * dw)) == 0;
      e_dout[id]  = chan(din, e_sel[id], w);
      e_valid[id] = 1'b1;
    end else if (m_scan[id] == 0 && mode && start && !stop) begin
      m_scan[id] = 1; m_t[id] = 0; e_sel[id] = 0;
      e_dout[id] = chan(din, 0, w); e_valid[id] = 1'b1; e_wrap[id] = 1'b0;
    end else begin
      m_scan[id] = 0; m_t[id] = 0; e_sel[id] = sel;
      e_valid[id] = (sel < n);
      e_dout[id]  = (sel < n) ? chan(din, sel, w) : 64'd0;
      e_wrap[id]  = 1'b0;
    end
  endtask

  task automatic tick();
    step_model(0, 16, 4, 1, 64'(bus16.din), bus16.mode, bus16.start, bus16.stop,
               int'(bus16.sel_in));
    step_model(1, 5, 1, 4, 64'(bus5.din), bus5.mode, bus5.start, bus5.stop,
               int'(bus5.sel_in));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus16.din = 16'h14A0; bus16.mode = 1'b0; bus16.sel_in = 4'd0;
    bus16.start = 1'b0; bus16.stop = 1'b0;
    bus5.din = 20'h54321; bus5.mode = 1'b0; bus5.sel_in = 3'd0;
    bus5.start = 1'b0; bus5.stop = 1'b0;
    tick();
    tick();
    checks += 5;
    if (bus16.dout !== 1'b0) begin errors++; $display("FAIL rst_dout: got %0h want 0", bus16.dout); end
    if (bus16.sel_out !== 4'd0) begin errors++; $display("FAIL rst_sel: got %0d want 0", bus16.sel_out); end
    if (bus16.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus16.valid); end
    if (bus16.wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap: got %0b want 0", bus16.wrap); end
    if (bus5.valid !== 1'b0) begin errors++; $display("FAIL rst_valid5: got %0b want 0", bus5.valid); end
  endtask

  task automatic test_manual();
    rst_n = 1'b1;
    bus16.mode = 1'b0;
    for (int s = 0; s < 16; s++) begin
      bus16.sel_in = 4'(s);
      tick();
      checks += 4;
      if (64'(bus16.dout) !== e_dout[0])
        begin errors++; $display("FAIL man_dout[%0d]: got %0h want %0h", s, bus16.dout, e_dout[0]); end
      if (bus16.dout !== ((s == 5 || s == 7 || s == 10 || s == 12) ? 1'b1 : 1'b0))
        begin errors++; $display("FAIL man_pattern[%0d]: got %0h", s, bus16.dout); end
      if (int'(bus16.sel_out) !== s)
        begin errors++; $display("FAIL man_sel: got %0d want %0d", bus16.sel_out, s); end
      if (bus16.valid !== 1'b1)
        begin errors++; $display("FAIL man_valid[%0d]: got %0b want 1", s, bus16.valid); end
    end
  endtask

  task automatic test_scan();
    int wraps = 0;
    int wrap_at = -1;
    bus16.mode = 1'b1; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    checks += 3;
    if (bus16.sel_out !== 4'd0) begin errors++; $display("FAIL scan_entry_sel: got %0d want 0", bus16.sel_out); end
    if (bus16.valid !== 1'b1) begin errors++; $display("FAIL scan_entry_valid: got %0b want 1", bus16.valid); end
    if (bus16.wrap !== 1'b0) begin errors++; $display("FAIL scan_entry_wrap: got %0b want 0", bus16.wrap); end
    for (int c = 1; c <= 68; c++) begin
      tick();
      checks += 3;
      if (int'(bus16.sel_out) !== e_sel[0])
        begin errors++; $display("FAIL scan_sel[%0d]: got %0d want %0d", c, bus16.sel_out, e_sel[0]); end
      if (64'(bus16.dout) !== e_dout[0])
        begin errors++; $display("FAIL scan_dout[%0d]: got %0h want %0h", c, bus16.dout, e_dout[0]); end
      if (bus16.wrap !== e_wrap[0])
        begin errors++; $display("FAIL scan_wrap[%0d]: got %0b want %0b", c, bus16.wrap, e_wrap[0]); end
      if (bus16.wrap === 1'b1) begin wraps++; wrap_at = c; end
    end
    checks += 2;
    if (wraps !== 1) begin errors++; $display("FAIL scan_wrap_count: got %0d want 1", wraps); end
    if (wrap_at !== 64) begin errors++; $display("FAIL scan_wrap_cycle: got %0d want 64", wrap_at); end
  endtask

  task automatic test_stop_priority();
    int guard = 0;
    while (e_sel[0] != 9 && guard < 80) begin tick(); guard++; end
    checks++;
    if (e_sel[0] != 9) begin errors++; $display("FAIL stop_reach9: got %0d want 9", e_sel[0]); end
    bus16.start = 1'b1; bus16.stop = 1'b1; bus16.sel_in = 4'd3;
    tick();
    bus16.start = 1'b0; bus16.stop = 1'b0;
    checks += 3;
    if (bus16.sel_out !== 4'd3) begin errors++; $display("FAIL stop_sel: got %0d want 3", bus16.sel_out); end
    if (64'(bus16.dout) !== e_dout[0])
      begin errors++; $display("FAIL stop_dout: got %0h want %0h", bus16.dout, e_dout[0]); end
    if (bus16.wrap !== 1'b0) begin errors++; $display("FAIL stop_wrap: got %0b want 0", bus16.wrap); end
    bus16.sel_in = 4'd4;
    tick();
    checks++;
    if (bus16.sel_out !== 4'd4) begin errors++; $display("FAIL idle_mode1: got %0d want 4", bus16.sel_out); end
  endtask

  task automatic test_reset_mid_scan();
    int guard = 0;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    while (e_sel[0] != 6 && guard < 80) begin tick(); guard++; end
    checks++;
    if (bus16.sel_out !== 4'd6) begin errors++; $display("FAIL mid_reach6: got %0d want 6", bus16.sel_out); end
    rst_n = 1'b0;
    tick();
    checks += 4;
    if (bus16.dout !== 1'b0) begin errors++; $display("FAIL mid_rst_dout: got %0h want 0", bus16.dout); end
    if (bus16.sel_out !== 4'd0) begin errors++; $display("FAIL mid_rst_sel: got %0d want 0", bus16.sel_out); end
    if (bus16.valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus16.valid); end
    if (bus16.wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_wrap: got %0b want 0", bus16.wrap); end
    rst_n = 1'b1;
    bus16.mode = 1'b0;
  endtask

  task automatic test_non_pow2();
    logic [3:0] seq [6];
    seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3; seq[3] = 4'h4; seq[4] = 4'h5; seq[5] = 4'h1;
    bus5.din = 20'h54321; bus5.mode = 1'b1; bus5.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus5.start = 1'b0;
      checks += 3;
      if (bus5.dout !== seq[i])
        begin errors++; $display("FAIL np2_dout[%0d]: got %0h want %0h", i, bus5.dout, seq[i]); end
      if (bus5.wrap !== (i == 5))
        begin errors++; $display("FAIL np2_wrap[%0d]: got %0b want %0b", i, bus5.wrap, i == 5); end
      if (64'(bus5.dout) !== e_dout[1])
        begin errors++; $display("FAIL np2_model[%0d]: got %0h want %0h", i, bus5.dout, e_dout[1]); end
    end
    bus5.mode = 1'b0; bus5.sel_in = 3'd6;
    tick();
    checks += 3;
    if (bus5.dout !== 4'h0) begin errors++; $display("FAIL np2_oor_dout: got %0h want 0", bus5.dout); end
    if (bus5.valid !== 1'b0) begin errors++; $display("FAIL np2_oor_valid: got %0b want 0", bus5.valid); end
    if (bus5.sel_out !== 3'd6) begin errors++; $display("FAIL np2_oor_sel: got %0d want 6", bus5.sel_out); end
  endtask

  task automatic test_live_data();
    int guard = 0;
    logic nb;
    bus16.din = 16'($urandom);
    bus16.mode = 1'b1; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    while (e_sel[0] != 2 && guard < 80) begin tick(); guard++; end
    tick();
    nb = ~bus16.din[2];
    bus16.din[2] = nb;
    tick();
    checks += 3;
    if (bus16.sel_out !== 4'd2) begin errors++; $display("FAIL live_sel: got %0d want 2", bus16.sel_out); end
    if (bus16.dout !== nb) begin errors++; $display("FAIL live_dout: got %0b want %0b", bus16.dout, nb); end
    if (64'(bus16.dout) !== e_dout[0])
      begin errors++; $display("FAIL live_model: got %0h want %0h", bus16.dout, e_dout[0]); end
    bus16.mode = 1'b0;
    bus16.sel_in = 4'($urandom);
    tick();
    checks += 3;
    if (bus16.wrap !== 1'b0) begin errors++; $display("FAIL drop_wrap: got %0b want 0", bus16.wrap); end
    if (bus16.sel_out !== bus16.sel_in)
      begin errors++; $display("FAIL drop_sel: got %0d want %0d", bus16.sel_out, bus16.sel_in); end
    if (64'(bus16.dout) !== e_dout[0])
      begin errors++; $display("FAIL drop_dout: got %0h want %0h", bus16.dout, e_dout[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n        = ($urandom_range(49) != 0);
      bus16.din    = 16'($urandom);
      bus16.mode   = ($urandom_range(9) != 0);
      bus16.start  = ($urandom_range(7) == 0);
      bus16.stop   = ($urandom_range(29) == 0);
      bus16.sel_in = 4'($urandom);
      bus5.din     = 20'($urandom);
      bus5.mode    = ($urandom_range(9) != 0);
      bus5.start   = ($urandom_range(5) == 0);
      bus5.stop    = ($urandom_range(19) == 0);
      bus5.sel_in  = 3'($urandom_range(7));
      tick();
      checks += 8;
      if (int'(bus16.sel_out) !== e_sel[0])
        begin errors++; $display("FAIL rnd_sel16[%0d]: got %0d want %0d", c, bus16.sel_out, e_sel[0]); end
      if (64'(bus16.dout) !== e_dout[0])
        begin errors++; $display("FAIL rnd_dout16[%0d]: got %0h want %0h", c, bus16.dout, e_dout[0]); end
      if (bus16.valid !== e_valid[0])
        begin errors++; $display("FAIL rnd_valid16[%0d]: got %0b want %0b", c, bus16.valid, e_valid[0]); end
      if (bus16.wrap !== e_wrap[0])
        begin errors++; $display("FAIL rnd_wrap16[%0d]: got %0b want %0b", c, bus16.wrap, e_wrap[0]); end
      if (int'(bus5.sel_out) !== e_sel[1])
        begin errors++; $display("FAIL rnd_sel5[%0d]: got %0d want %0d", c, bus5.sel_out, e_sel[1]); end
      if (64'(bus5.dout) !== e_dout[1])
        begin errors++; $display("FAIL rnd_dout5[%0d]: got %0h want %0h", c, bus5.dout, e_dout[1]); end
      if (bus5.valid !== e_valid[1])
        begin errors++; $display("FAIL rnd_valid5[%0d]: got %0b want %0b", c, bus5.valid, e_valid[1]); end
      if (bus5.wrap !== e_wrap[1])
        begin errors++; $display("FAIL rnd_wrap5[%0d]: got %0b want %0b", c, bus5.wrap, e_wrap[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_stop_priority();
    test_reset_mid_scan();
    test_non_pow2();
    test_live_data();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
